write_back_unit: RTL and testbench

WRITE_BACK_UNIT -- requirements
Module: write_back_unit

---
 rtl/write_back_unit.sv | 265 ++++++++++++++++++++++++++
 tb/tb_write_back_unit.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/write_back_unit.sv
// -----------------------------------------------------------------------------
// write_back_unit
//
// Final pipeline stage of a Y86 core. Holds one staged instruction result,
// commits it to the architectural register file one cycle after acceptance,
// and serves two combinational decode read ports with same-cycle bypass of
// the values being committed.
//
// Ports
//   clock          : rising-edge clock
//   reset_n        : asynchronous active-low reset
//   in_valid       : upstream entry valid
//   in_ready       : stage can accept an entry this cycle
//   stall          : hold the staged entry (no commit)
//   icode          : Y86 instruction code of the entry
//   rA, rB         : register specifiers (4'hF = none)
//   cnd            : condition outcome, used by icode 2 (cmov)
//   valE, valM     : ALU result and memory result
//   rd_addr1/2     : decode read indices
//   rd_data1/2     : decode read data (bypassed from the committing entry)
//   halted         : sticky, a halt instruction has retired
//   error          : sticky, an invalid icode has retired
//   retired_count  : number of retired entries, wraps
// -----------------------------------------------------------------------------
module write_back_unit #(
    parameter int WIDTH = 32,
    parameter int NREGS = 8,
    parameter int RSP   = 4,
    parameter int CNT_W = 16
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             stall,
    input  logic [3:0]       icode,
    input  logic [3:0]       rA,
    input  logic [3:0]       rB,
    input  logic             cnd,
    input  logic [WIDTH-1:0] valE,
    input  logic [WIDTH-1:0] valM,
    input  logic [3:0]       rd_addr1,
    input  logic [3:0]       rd_addr2,
    output logic [WIDTH-1:0] rd_data1,
    output logic [WIDTH-1:0] rd_data2,
    output logic             halted,
    output logic             error,
    output logic [CNT_W-1:0] retired_count
);

    localparam logic [3:0] RSP_IDX = 4'(RSP);

    // A register index is writable/readable only if it names a real register.
    function automatic logic idx_ok(input logic [3:0] idx);
        return (idx != 4'hF) && (int'(idx) < NREGS);
    endfunction

    // Staged entry
    logic             st_valid_q, st_valid_d;
    logic [3:0]       st_icode_q, st_icode_d;
    logic [3:0]       st_ra_q,    st_ra_d;
    logic [3:0]       st_rb_q,    st_rb_d;
    logic             st_cnd_q,   st_cnd_d;
    logic [WIDTH-1:0] st_vale_q,  st_vale_d;
    logic [WIDTH-1:0] st_valm_q,  st_valm_d;

    // Status
    logic             halted_q, halted_d;
    logic             error_q,  error_d;
    logic [CNT_W-1:0] count_q,  count_d;

    // Register file
    logic [WIDTH-1:0] regs_q [NREGS];
    logic [WIDTH-1:0] regs_d [NREGS];

    // Control and write-port decode
    logic             commit_s;
    logic             accept_s;
    logic             halt_hit_s;
    logic             err_hit_s;
    logic             wr1_en_s,   wr2_en_s;
    logic [3:0]       wr1_addr_s, wr2_addr_s;
    logic [WIDTH-1:0] wr1_data_s, wr2_data_s;
    logic             wr1_go_s,   wr2_go_s;
    logic [WIDTH-1:0] rf_rd1_s,   rf_rd2_s;

    // Accept and commit may coincide: a committing slot frees itself this cycle.
    assign commit_s = st_valid_q && !stall;
    assign in_ready = !halted_q && !error_q && (!st_valid_q || !stall);
    assign accept_s = in_valid && in_ready;

    assign halted        = halted_q;
    assign error         = error_q;
    assign retired_count = count_q;

    // Decode the staged icode into up to two register write ports.
    always_comb begin
        wr1_en_s   = 1'b0;
        wr1_addr_s = 4'hF;
        wr1_data_s = '0;
        wr2_en_s   = 1'b0;
        wr2_addr_s = 4'hF;
        wr2_data_s = '0;
        halt_hit_s = 1'b0;
        err_hit_s  = 1'b0;
        case (st_icode_q)
            4'h0: begin
                halt_hit_s = 1'b1;
            end
            4'h1, 4'h4, 4'h7: begin
                wr1_en_s = 1'b0;
            end
            4'h2: begin
                wr1_en_s   = st_cnd_q;
                wr1_addr_s = st_rb_q;
                wr1_data_s = st_vale_q;
            end
            4'h3, 4'h6: begin
                wr1_en_s   = 1'b1;
                wr1_addr_s = st_rb_q;
                wr1_data_s = st_vale_q;
            end
            4'h5: begin
                wr2_en_s   = 1'b1;
                wr2_addr_s = st_ra_q;
                wr2_data_s = st_valm_q;
            end
            4'h8, 4'h9, 4'hA: begin
                wr1_en_s   = 1'b1;
                wr1_addr_s = RSP_IDX;
                wr1_data_s = st_vale_q;
            end
            4'hB: begin
                // popl: stack pointer update on port1, popped value on port2;
                // port2 wins for "popl %esp".
                wr1_en_s   = 1'b1;
                wr1_addr_s = RSP_IDX;
                wr1_data_s = st_vale_q;
                wr2_en_s   = 1'b1;
                wr2_addr_s = st_ra_q;
                wr2_data_s = st_valm_q;
            end
            default: begin
                err_hit_s = 1'b1;
            end
        endcase
    end

    // Writes happen only on commit and only to existing registers.
    assign wr1_go_s = commit_s && wr1_en_s && idx_ok(wr1_addr_s);
    assign wr2_go_s = commit_s && wr2_en_s && idx_ok(wr2_addr_s);

    // Next state of the staged slot and status flags.
    always_comb begin
        st_valid_d = st_valid_q;
        st_icode_d = st_icode_q;
        st_ra_d    = st_ra_q;
        st_rb_d    = st_rb_q;
        st_cnd_d   = st_cnd_q;
        st_vale_d  = st_vale_q;
        st_valm_d  = st_valm_q;
        halted_d   = halted_q;
        error_d    = error_q;
        count_d    = count_q;
        if (accept_s) begin
            st_valid_d = 1'b1;
            st_icode_d = icode;
            st_ra_d    = rA;
            st_rb_d    = rB;
            st_cnd_d   = cnd;
            st_vale_d  = valE;
            st_valm_d  = valM;
        end else if (commit_s) begin
            st_valid_d = 1'b0;
        end else begin
            st_valid_d = st_valid_q;
        end
        if (commit_s) begin
            count_d  = count_q + {{(CNT_W-1){1'b0}}, 1'b1};
            halted_d = halted_q | halt_hit_s;
            error_d  = error_q | err_hit_s;
        end else begin
            count_d = count_q;
        end
    end

    // Register file next state; port2 has priority over port1.
    always_comb begin
        for (int i = 0; i < NREGS; i++) begin
            if (wr2_go_s && (wr2_addr_s == 4'(i))) begin
                regs_d[i] = wr2_data_s;
            end else if (wr1_go_s && (wr1_addr_s == 4'(i))) begin
                regs_d[i] = wr1_data_s;
            end else begin
                regs_d[i] = regs_q[i];
            end
        end
    end

    // Read ports: array lookup (0 for non-existent indices), then bypass of
    // the committing writes, port2 first.
    always_comb begin
        rf_rd1_s = '0;
        rf_rd2_s = '0;
        for (int i = 0; i < NREGS; i++) begin
            rf_rd1_s = (rd_addr1 == 4'(i)) ? regs_q[i] : rf_rd1_s;
            rf_rd2_s = (rd_addr2 == 4'(i)) ? regs_q[i] : rf_rd2_s;
        end
        if (wr2_go_s && (wr2_addr_s == rd_addr1)) begin
            rd_data1 = wr2_data_s;
        end else if (wr1_go_s && (wr1_addr_s == rd_addr1)) begin
            rd_data1 = wr1_data_s;
        end else begin
            rd_data1 = rf_rd1_s;
        end
        if (wr2_go_s && (wr2_addr_s == rd_addr2)) begin
            rd_data2 = wr2_data_s;
        end else if (wr1_go_s && (wr1_addr_s == rd_addr2)) begin
            rd_data2 = wr1_data_s;
        end else begin
            rd_data2 = rf_rd2_s;
        end
    end

    // Staged slot and status state registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            st_valid_q <= 1'b0;
            st_icode_q <= 4'h0;
            st_ra_q    <= 4'hF;
            st_rb_q    <= 4'hF;
            st_cnd_q   <= 1'b0;
            st_vale_q  <= '0;
            st_valm_q  <= '0;
            halted_q   <= 1'b0;
            error_q    <= 1'b0;
            count_q    <= '0;
        end else begin
            st_valid_q <= st_valid_d;
            st_icode_q <= st_icode_d;
            st_ra_q    <= st_ra_d;
            st_rb_q    <= st_rb_d;
            st_cnd_q   <= st_cnd_d;
            st_vale_q  <= st_vale_d;
            st_valm_q  <= st_valm_d;
            halted_q   <= halted_d;
            error_q    <= error_d;
            count_q    <= count_d;
        end
    end

    // Architectural register file storage.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= regs_d[i];
            end
        end
    end

endmodule

// File: tb/tb_write_back_unit.sv
module tb_write_back_unit;

    localparam int WIDTH = 32;
    localparam int NREGS = 8;
    localparam int RSP   = 4;
    localparam int CNT_W = 4;

    logic             clock = 1'b0;
    logic             reset_n;
    logic             in_valid;
    logic             in_ready;
    logic             stall;
    logic [3:0]       icode;
    logic [3:0]       rA;
    logic [3:0]       rB;
    logic             cnd;
    logic [WIDTH-1:0] valE;
    logic [WIDTH-1:0] valM;
    logic [3:0]       rd_addr1;
    logic [3:0]       rd_addr2;
    logic [WIDTH-1:0] rd_data1;
    logic [WIDTH-1:0] rd_data2;
    logic             halted;
    logic             error;
    logic [CNT_W-1:0] retired_count;

    int n_vec = 0;
    int n_err = 0;
    int exp_cnt = 0;

    write_back_unit #(
        .WIDTH(WIDTH), .NREGS(NREGS), .RSP(RSP), .CNT_W(CNT_W)
    ) dut (
        .clock(clock), .reset_n(reset_n),
        .in_valid(in_valid), .in_ready(in_ready), .stall(stall),
        .icode(icode), .rA(rA), .rB(rB), .cnd(cnd),
        .valE(valE), .valM(valM),
        .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
        .rd_data1(rd_data1), .rd_data2(rd_data2),
        .halted(halted), .error(error), .retired_count(retired_count)
    );

    always #5 clock = ~clock;

    task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Present one entry for a single edge.
    task automatic send(input logic [3:0] ic, input logic [3:0] ra, input logic [3:0] rb,
                        input logic c, input logic [31:0] e, input logic [31:0] m);
        icode = ic; rA = ra; rB = rb; cnd = c; valE = e; valM = m;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    // Accept then commit one entry.
    task automatic run(input logic [3:0] ic, input logic [3:0] ra, input logic [3:0] rb,
                       input logic c, input logic [31:0] e, input logic [31:0] m);
        send(ic, ra, rb, c, e, m);
        tick();
        exp_cnt++;
    endtask

    task automatic rd1(input string tag, input logic [3:0] a, input logic [31:0] exp);
        rd_addr1 = a;
        #1;
        chk_eq(tag, rd_data1, exp);
    endtask

    task automatic rd2(input string tag, input logic [3:0] a, input logic [31:0] exp);
        rd_addr2 = a;
        #1;
        chk_eq(tag, rd_data2, exp);
    endtask

    task automatic chk_cnt(input string tag);
        chk_eq(tag, retired_count, exp_cnt % (1 << CNT_W));
    endtask

    task automatic pulse_reset();
        reset_n = 1'b0;
        #2;
        reset_n = 1'b1;
        #1;
        exp_cnt = 0;
    endtask

    initial begin
        reset_n = 1'b0; in_valid = 1'b0; stall = 1'b0;
        icode = 4'h1; rA = 4'hF; rB = 4'hF; cnd = 1'b0;
        valE = 32'h0; valM = 32'h0; rd_addr1 = 4'h0; rd_addr2 = 4'h0;
        #12;
        reset_n = 1'b1;
        #1;
        chk_eq("rst_ready", in_ready, 1'b1);
        chk_eq("rst_halted", halted, 1'b0);
        chk_eq("rst_error", error, 1'b0);
        chk_cnt("rst_count");
        rd1("rst_reg2", 4'h2, 32'h0);

        // irmovl: bypass in the commit cycle, then stored value
        send(4'h3, 4'hF, 4'h2, 1'b0, 32'h1234, 32'h0);
        rd1("irmov_bypass", 4'h2, 32'h1234);
        chk_cnt("irmov_cnt_pre");
        tick(); exp_cnt++;
        rd1("irmov_reg2", 4'h2, 32'h1234);
        chk_cnt("irmov_cnt");

        // popl %esp: port2 (valM) wins over port1 (valE)
        send(4'hB, 4'h4, 4'hF, 1'b0, 32'h100, 32'hBEEF);
        rd1("popl_bypass", 4'h4, 32'hBEEF);
        tick(); exp_cnt++;
        rd1("popl_reg4", 4'h4, 32'hBEEF);
        chk_cnt("popl_cnt");

        // pushl writes valE to the stack pointer
        run(4'hA, 4'h3, 4'hF, 1'b0, 32'hFC, 32'h0);
        rd1("push_reg4", 4'h4, 32'hFC);

        // mrmovl writes valM to rA, checked on port 2
        run(4'h5, 4'h3, 4'hF, 1'b0, 32'h0, 32'hAAAA);
        rd2("mrmov_reg3", 4'h3, 32'hAAAA);

        // cmov with cnd=0 then cnd=1
        run(4'h2, 4'h0, 4'h1, 1'b0, 32'h5, 32'h0);
        rd1("cmov0_reg1", 4'h1, 32'h0);
        chk_cnt("cmov0_cnt");
        run(4'h2, 4'h0, 4'h1, 1'b1, 32'h5, 32'h0);
        rd1("cmov1_reg1", 4'h1, 32'h5);
        chk_cnt("cmov1_cnt");

        // stall holds the staged entry for 3 cycles
        stall = 1'b1;
        send(4'h6, 4'h0, 4'h5, 1'b0, 32'h77, 32'h0);
        for (int k = 0; k < 3; k++) begin
            chk_eq("stall_ready", in_ready, 1'b0);
            rd1("stall_reg5", 4'h5, 32'h0);
            chk_cnt("stall_cnt");
            tick();
        end
        stall = 1'b0;
        #1;
        rd1("unstall_bypass", 4'h5, 32'h77);
        tick(); exp_cnt++;
        rd1("unstall_reg5", 4'h5, 32'h77);
        chk_cnt("unstall_cnt");
        tick();
        chk_cnt("unstall_once");

        // suppressed writes still retire
        run(4'h3, 4'hF, 4'hF, 1'b0, 32'hDEAD, 32'h0);
        chk_cnt("rbF_cnt");
        rd1("rbF_read", 4'hF, 32'h0);
        rd2("rbF_reg2", 4'h2, 32'h1234);
        run(4'h3, 4'hF, 4'(NREGS), 1'b0, 32'hDEAD, 32'h0);
        chk_cnt("rbN_cnt");
        rd1("rbN_read", 4'(NREGS), 32'h0);
        rd2("rbN_reg0", 4'h0, 32'h0);

        // retired_count wrap
        while (exp_cnt < (1 << CNT_W) - 1) begin
            run(4'h1, 4'hF, 4'hF, 1'b0, 32'h0, 32'h0);
        end
        chk_cnt("cnt_max");
        run(4'h1, 4'hF, 4'hF, 1'b0, 32'h0, 32'h0);
        chk_eq("cnt_wrap", retired_count, 4'h0);

        // invalid icode: sticky error, no write, further inputs ignored
        run(4'hD, 4'h2, 4'h2, 1'b1, 32'h9999, 32'h9999);
        chk_eq("err_flag", error, 1'b1);
        chk_eq("err_ready", in_ready, 1'b0);
        chk_eq("err_halted", halted, 1'b0);
        rd1("err_reg2", 4'h2, 32'h1234);
        send(4'h3, 4'hF, 4'h2, 1'b0, 32'h5555, 32'h0);
        tick();
        rd1("err_ignore", 4'h2, 32'h1234);
        chk_cnt("err_cnt");

        // reset clears error; a staged entry is discarded by reset
        pulse_reset();
        chk_eq("rst2_error", error, 1'b0);
        rd1("rst2_reg2", 4'h2, 32'h0);
        stall = 1'b1;
        send(4'h3, 4'hF, 4'h6, 1'b0, 32'h66, 32'h0);
        pulse_reset();
        stall = 1'b0;
        tick();
        tick();
        rd1("midrst_reg6", 4'h6, 32'h0);
        chk_cnt("midrst_cnt");
        chk_eq("midrst_ready", in_ready, 1'b1);

        // halt: sticky, blocks input; reset clears it and the registers
        run(4'h3, 4'hF, 4'h7, 1'b0, 32'h7777, 32'h0);
        rd1("pre_halt_reg7", 4'h7, 32'h7777);
        run(4'h0, 4'hF, 4'h2, 1'b0, 32'h1, 32'h1);
        chk_eq("halt_flag", halted, 1'b1);
        chk_eq("halt_ready", in_ready, 1'b0);
        chk_eq("halt_err", error, 1'b0);
        chk_cnt("halt_cnt");
        rd1("halt_nowrite", 4'h2, 32'h0);
        send(4'h3, 4'hF, 4'h2, 1'b0, 32'h55, 32'h0);
        tick();
        rd1("halt_ignore", 4'h2, 32'h0);
        chk_cnt("halt_cnt2");
        pulse_reset();
        chk_eq("rst3_halted", halted, 1'b0);
        chk_eq("rst3_ready", in_ready, 1'b1);
        for (int r = 0; r < NREGS; r++) begin
            rd1("rst3_regs", 4'(r), 32'h0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
